dmem_arbiter: RTL and testbench

- Shares the single-port data memory (dmem) between two requesters: the miniRV core load/store path (port C) and a debug/loader master (port D).
- Sits between the core datapath (alu_c address, rD2 write data, dram_we) and dmem.
- Core has fixed priority. A starvation counter forces a debug grant after MAX_WAIT denied cycles.
- Generates the core stall and returns read data to the owning requester after the memory read latency.

---
 rtl/dmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: core (C) has fixed priority,
// debug master (D) is protected by a starvation counter. Optional DMEM_ARB_LOCK_EN adds a D lock.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_stall_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              d_lock_i,
`endif
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [7:0]        wait_cnt_o
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  logic       force_reg;
  logic       force_next;
  logic [7:0] wait_cnt_reg;
  logic [7:0] wait_cnt_next;
  logic       owned;

  // While D owns the memory, C is locked out even if D is idle this cycle.
  assign c_gnt_o = ~rst_i & ~owned & c_req_i & ~(force_reg & d_req_i);
  assign d_gnt_o = ~rst_i & d_req_i & (owned | force_reg | ~c_req_i);
  assign c_stall_o = c_req_i & ~c_gnt_o;

  assign mem_addr_o  = d_gnt_o ? d_addr_i  : c_addr_i;
  assign mem_wdata_o = d_gnt_o ? d_wdata_i : c_wdata_i;
  assign mem_we_o    = (c_gnt_o & c_we_i) | (d_gnt_o & d_we_i);

  // A grant in the saturating cycle wins: the counter clears and force stays low.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (~d_req_i | d_gnt_o) begin
      wait_cnt_next = 8'd0;
    end else if (wait_cnt_reg != MAX_CNT) begin
      wait_cnt_next = wait_cnt_reg + 8'd1;
    end
  end

  assign force_next = (wait_cnt_next == MAX_CNT);
  assign wait_cnt_o = wait_cnt_reg;

`ifdef DMEM_ARB_LOCK_EN
  logic owned_reg;
  assign owned = owned_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owned_reg <= 1'b0;
    end else begin
      owned_reg <= d_lock_i & (owned_reg | d_gnt_o);
    end
  end
`else
  assign owned = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_reg <= 8'd0;
      force_reg    <= 1'b0;
    end else if (!owned) begin
      wait_cnt_reg <= wait_cnt_next;
      force_reg    <= force_next;
    end
  end

  // Read tags: {valid, owner}, owner=1 means port D.
  logic push_valid;
  logic push_owner;
  logic ret_valid;
  logic ret_owner;

  assign push_valid = (c_gnt_o & ~c_we_i) | (d_gnt_o & ~d_we_i);
  assign push_owner = d_gnt_o;

  generate
    if (RD_LAT == 0) begin : g_comb_ret
      assign ret_valid = push_valid;
      assign ret_owner = push_owner;
    end else begin : g_tag_pipe
      logic [RD_LAT-1:0] tag_valid_reg;
      logic [RD_LAT-1:0] tag_owner_reg;
      logic [RD_LAT-1:0] tag_valid_next;
      logic [RD_LAT-1:0] tag_owner_next;

      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
        if (gi == 0) begin : g_head
          assign tag_valid_next[gi] = push_valid;
          assign tag_owner_next[gi] = push_owner;
        end else begin : g_body
          assign tag_valid_next[gi] = tag_valid_reg[gi-1];
          assign tag_owner_next[gi] = tag_owner_reg[gi-1];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          tag_valid_reg <= '0;
          tag_owner_reg <= '0;
        end else begin
          tag_valid_reg <= tag_valid_next;
          tag_owner_reg <= tag_owner_next;
        end
      end

      assign ret_valid = tag_valid_reg[RD_LAT-1];
      assign ret_owner = tag_owner_reg[RD_LAT-1];
    end
  endgenerate

  logic [DATA_W-1:0] c_rdata_reg;
  logic [DATA_W-1:0] d_rdata_reg;

  // Gating with reset drops any tag still emerging from before the reset edge.
  assign c_rvalid_o = ret_valid & ~ret_owner & ~rst_i;
  assign d_rvalid_o = ret_valid &  ret_owner & ~rst_i;

  // Data is live in the return cycle and held afterwards.
  assign c_rdata_o = c_rvalid_o ? mem_rdata_i : c_rdata_reg;
  assign d_rdata_o = d_rvalid_o ? mem_rdata_i : d_rdata_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_rdata_reg <= '0;
      d_rdata_reg <= '0;
    end else begin
      if (c_rvalid_o) c_rdata_reg <= mem_rdata_i;
      if (d_rvalid_o) d_rdata_reg <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (RD_LAT=1, MAX_WAIT=4); lock steps run when DMEM_ARB_LOCK_EN is defined.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        c_req_i, c_we_i, d_req_i, d_we_i;
  logic [31:0] c_addr_i, c_wdata_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic        c_gnt_o, c_stall_o, c_rvalid_o, d_gnt_o, d_rvalid_o, mem_we_o;
  logic [31:0] c_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [7:0]  wait_cnt_o;
`ifdef DMEM_ARB_LOCK_EN
  logic        d_lock_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .c_gnt_o(c_gnt_o), .c_stall_o(c_stall_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
`ifdef DMEM_ARB_LOCK_EN
    .d_lock_i(d_lock_i),
`endif
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .wait_cnt_o(wait_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    c_req_i = 0; c_we_i = 0; c_addr_i = 0; c_wdata_i = 0;
    d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0;
    mem_rdata_i = 0;
  endtask

  initial begin
    idle();
`ifdef DMEM_ARB_LOCK_EN
    d_lock_i = 0;
`endif
    // Reset with both ports requesting writes: nothing may be granted
    rst_i = 1; c_req_i = 1; c_we_i = 1; d_req_i = 1; d_we_i = 1;
    next_cycle(); next_cycle();
    @(negedge clk);
    check("rst_c_gnt", 32'(c_gnt_o), 0);
    check("rst_d_gnt", 32'(d_gnt_o), 0);
    check("rst_mem_we", 32'(mem_we_o), 0);
    check("rst_wait_cnt", 32'(wait_cnt_o), 0);
    check("rst_c_rvalid", 32'(c_rvalid_o), 0);
    check("rst_d_rvalid", 32'(d_rvalid_o), 0);
    check("rst_c_rdata", c_rdata_o, 0);
    check("rst_d_rdata", d_rdata_o, 0);
    next_cycle();
    rst_i = 0; idle();

    // Core-only read
    c_req_i = 1; c_addr_i = 32'h10;
    @(negedge clk);
    check("core_gnt", 32'(c_gnt_o), 1);
    check("core_stall", 32'(c_stall_o), 0);
    check("core_mem_addr", mem_addr_o, 32'h10);
    check("core_mem_we", 32'(mem_we_o), 0);
    next_cycle();
    c_req_i = 0; mem_rdata_i = 32'hDEADBEEF;
    @(negedge clk);
    check("core_rvalid", 32'(c_rvalid_o), 1);
    check("core_rdata", c_rdata_o, 32'hDEADBEEF);
    check("core_d_rvalid", 32'(d_rvalid_o), 0);
    next_cycle();
    mem_rdata_i = 0;
    @(negedge clk);
    check("core_rvalid_pulse", 32'(c_rvalid_o), 0);
    check("core_rdata_hold", c_rdata_o, 32'hDEADBEEF);
    next_cycle();

    // Simultaneous: C write wins, D read follows
    c_req_i = 1; c_we_i = 1; c_addr_i = 32'h20; c_wdata_i = 32'h1234;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h24;
    @(negedge clk);
    check("sim_c_gnt", 32'(c_gnt_o), 1);
    check("sim_d_gnt0", 32'(d_gnt_o), 0);
    check("sim_mem_we", 32'(mem_we_o), 1);
    check("sim_mem_addr", mem_addr_o, 32'h20);
    check("sim_mem_wdata", mem_wdata_o, 32'h1234);
    next_cycle();
    c_req_i = 0; c_we_i = 0;
    @(negedge clk);
    check("sim_d_gnt1", 32'(d_gnt_o), 1);
    check("sim_mem_addr_d", mem_addr_o, 32'h24);
    check("sim_mem_we_d", 32'(mem_we_o), 0);
    check("sim_wait_cnt1", 32'(wait_cnt_o), 1);
    check("sim_c_rvalid1", 32'(c_rvalid_o), 0);
    next_cycle();
    d_req_i = 0; mem_rdata_i = 32'hCAFEF00D;
    @(negedge clk);
    check("sim_d_rvalid", 32'(d_rvalid_o), 1);
    check("sim_d_rdata", d_rdata_o, 32'hCAFEF00D);
    check("sim_c_rvalid2", 32'(c_rvalid_o), 0);
    check("sim_wait_cnt2", 32'(wait_cnt_o), 0);
    next_cycle();
    mem_rdata_i = 0;

    // Starvation: C writes continuously, D granted at cycle 4
    c_req_i = 1; c_we_i = 1; c_addr_i = 32'h40;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h44;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("starve_cnt_c%0d", k), 32'(wait_cnt_o), (k <= 4) ? k : 0);
      check($sformatf("starve_d_gnt_c%0d", k), 32'(d_gnt_o), (k == 4) ? 1 : 0);
      check($sformatf("starve_c_gnt_c%0d", k), 32'(c_gnt_o), (k == 4) ? 0 : 1);
      check($sformatf("starve_stall_c%0d", k), 32'(c_stall_o), (k == 4) ? 1 : 0);
      next_cycle();
      if (k == 4) d_req_i = 0;
    end
    idle();
    next_cycle();

    // Ordering: C@0x0, D@0x4, C@0x8
    c_req_i = 1; c_addr_i = 32'h0;
    d_req_i = 1; d_addr_i = 32'h4;
    @(negedge clk);
    check("ord_c_gnt0", 32'(c_gnt_o), 1);
    next_cycle();
    c_req_i = 0; mem_rdata_i = 32'h11111111;
    @(negedge clk);
    check("ord_d_gnt1", 32'(d_gnt_o), 1);
    check("ord_c_rvalid1", 32'(c_rvalid_o), 1);
    check("ord_c_rdata1", c_rdata_o, 32'h11111111);
    check("ord_d_rvalid1", 32'(d_rvalid_o), 0);
    next_cycle();
    d_req_i = 0; c_req_i = 1; c_addr_i = 32'h8; mem_rdata_i = 32'h22222222;
    @(negedge clk);
    check("ord_c_gnt2", 32'(c_gnt_o), 1);
    check("ord_d_rvalid2", 32'(d_rvalid_o), 1);
    check("ord_d_rdata2", d_rdata_o, 32'h22222222);
    check("ord_c_rvalid2", 32'(c_rvalid_o), 0);
    next_cycle();
    c_req_i = 0; mem_rdata_i = 32'h33333333;
    @(negedge clk);
    check("ord_c_rvalid3", 32'(c_rvalid_o), 1);
    check("ord_c_rdata3", c_rdata_o, 32'h33333333);
    check("ord_d_rvalid3", 32'(d_rvalid_o), 0);
    check("ord_d_rdata_hold", d_rdata_o, 32'h22222222);
    next_cycle();
    idle();

    // Reset mid-read
    d_req_i = 1; d_addr_i = 32'h50;
    @(negedge clk);
    check("rmr_d_gnt", 32'(d_gnt_o), 1);
    next_cycle();
    rst_i = 1; mem_rdata_i = 32'h55555555;
    c_req_i = 1; c_we_i = 1; d_req_i = 1; d_we_i = 1;
    @(negedge clk);
    check("rmr_d_rvalid_rst", 32'(d_rvalid_o), 0);
    check("rmr_c_gnt_rst", 32'(c_gnt_o), 0);
    check("rmr_d_gnt_rst", 32'(d_gnt_o), 0);
    check("rmr_mem_we_rst", 32'(mem_we_o), 0);
    next_cycle();
    rst_i = 0;
    @(negedge clk);
    check("rmr_wait_cnt", 32'(wait_cnt_o), 0);
    check("rmr_d_rvalid_after", 32'(d_rvalid_o), 0);
    check("rmr_d_rdata_after", d_rdata_o, 0);
    check("rmr_c_gnt_after", 32'(c_gnt_o), 1);
    next_cycle();
    idle();
    next_cycle();

`ifdef DMEM_ARB_LOCK_EN
    // Lock: D owns the memory for 3 cycles while C keeps requesting
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h60; d_lock_i = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("lock_d_gnt_c%0d", k), 32'(d_gnt_o), 1);
      check($sformatf("lock_c_gnt_c%0d", k), 32'(c_gnt_o), 0);
      next_cycle();
      c_req_i = 1; c_we_i = 1; c_addr_i = 32'h64;
    end
    d_lock_i = 0; d_req_i = 0;
    @(negedge clk);
    check("lock_c_gnt_release", 32'(c_gnt_o), 0);
    next_cycle();
    @(negedge clk);
    check("lock_c_gnt_after", 32'(c_gnt_o), 1);
    next_cycle();
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
